// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit. Tracks the tags of in-flight
// instructions (EX, MEM, WB, ...), drives the EX operand forward selects and
// the MEM store-data select, and raises stall on a load-use dependency.

// Per-stage tag comparator: writer qualification plus four destination matches.
module fwd_stage_match #(
  parameter int REG_AW = 4
) (
  input  logic                   v,
  input  logic                   rw,
  input  logic [REG_AW-1:0]      rd,
  input  logic [3:0][REG_AW-1:0] q,
  output logic                   wr,
  output logic [3:0]             hit
);
  assign wr = v & rw & (rd != '0);
  for (genvar i = 0; i < 4; i++) begin : g_q
    assign hit[i] = wr & (rd == q[i]);
  end
endmodule

module fwd_hazard_unit #(
  parameter int REG_AW       = 4,
  parameter int DEPTH        = 3,
  parameter int SEL_W        = $clog2(DEPTH),
  parameter int LOAD_USE_CYC = 1,
  parameter int M2M_EN       = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              flush,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_a_sel,
  output logic [SEL_W-1:0]  fwd_b_sel,
  output logic              fwd_c_sel,
  output logic [CNT_W-1:0]  stall_count
);
  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic              rw;
    logic              ld;
    logic              st;
  } ent_t;

  ent_t [DEPTH-1:0]       ent;
  ent_t                   id_ent;
  logic [DEPTH-1:0]       wr;
  // hit[k]: 0 = EX rs, 1 = EX rt, 2 = ID rs, 3 = ID rt
  logic [DEPTH-1:0][3:0]  hit;
  logic [3:0][REG_AW-1:0] qry;
  logic                   stall_hit;
  logic                   m2m_store;

  assign qry = {id_rt, id_rs, ent[0].rt, ent[0].rs};

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    fwd_stage_match #(.REG_AW(REG_AW)) u_match (
      .v   (ent[k].v),
      .rw  (ent[k].rw),
      .rd  (ent[k].rd),
      .q   (qry),
      .wr  (wr[k]),
      .hit (hit[k])
    );
  end

  // Operand selects: scan oldest to youngest so the youngest producer wins.
  always_comb begin
    fwd_a_sel = '0;
    fwd_b_sel = '0;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (ent[0].v && hit[k][0]) fwd_a_sel = SEL_W'(k);
      if (ent[0].v && hit[k][1]) fwd_b_sel = SEL_W'(k);
    end
  end

  // A store whose data comes from a load one slot ahead gets it via mem-to-mem.
  assign m2m_store = (M2M_EN != 0) & id_memwrite;

  // Load-use detection over the stages a load result is not yet forwardable from.
  always_comb begin
    stall_hit = 1'b0;
    for (int k = 0; k < LOAD_USE_CYC; k++) begin
      if (ent[k].ld && (hit[k][2] ||
          (hit[k][3] && !(m2m_store && (k == LOAD_USE_CYC - 1)))))
        stall_hit = 1'b1;
    end
  end

  assign stall = id_valid & ~flush & stall_hit;

  if (DEPTH >= 3) begin : g_m2m
    assign fwd_c_sel = (M2M_EN != 0) & ent[1].v & ent[1].st & wr[2] &
                       (ent[2].rd == ent[1].rt) & (ent[1].rt != '0);
  end else begin : g_no_m2m
    assign fwd_c_sel = 1'b0;
  end

  assign id_ent = (id_valid && !stall && !flush) ?
                  '{v: 1'b1, rs: id_rs, rt: id_rt, rd: id_rd,
                    rw: id_regwrite, ld: id_memread, st: id_memwrite} : '0;

  // Tag pipeline: ID enters EX (bubble on stall/flush); flush also kills EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent <= '0;
    end else begin
      ent[0] <= id_ent;
      for (int k = 1; k < DEPTH; k++) ent[k] <= ent[k-1];
      if (flush) ent[1].v <= 1'b0;
    end
  end

  // Saturating stall-cycle counter for profiling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           stall_count <= '0;
    else if (stall && stall_count != '1)  stall_count <= stall_count + 1'b1;
  end

  // Tags kept for visibility but not consumed at every depth.
  logic unused_tags;
  assign unused_tags = ^{ent, hit};
endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [3:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic       id_regwrite = 1'b0, id_memread = 1'b0, id_memwrite = 1'b0, flush = 1'b0;

  always #5 clk = ~clk;

  logic        s0, s1, s2, s3, c0, c1, c2, c3;
  logic [1:0]  a0, a1, a2, a3, b0, b1, b2, b3;
  logic [15:0] n0, n1, n2;
  logic [2:0]  n3;

  fwd_hazard_unit u_def (.clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
    .id_rt(id_rt), .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .flush(flush), .stall(s0), .fwd_a_sel(a0), .fwd_b_sel(b0),
    .fwd_c_sel(c0), .stall_count(n0));
  fwd_hazard_unit #(.DEPTH(4), .LOAD_USE_CYC(2)) u_l2 (.clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .flush(flush), .stall(s1), .fwd_a_sel(a1), .fwd_b_sel(b1), .fwd_c_sel(c1),
    .stall_count(n1));
  fwd_hazard_unit #(.M2M_EN(0)) u_nm (.clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .flush(flush), .stall(s2),
    .fwd_a_sel(a2), .fwd_b_sel(b2), .fwd_c_sel(c2), .stall_count(n2));
  fwd_hazard_unit #(.CNT_W(3)) u_c3 (.clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .flush(flush), .stall(s3),
    .fwd_a_sel(a3), .fwd_b_sel(b3), .fwd_c_sel(c3), .stall_count(n3));

  int n_pass = 0, n_tot = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Reference model: list of in-flight instructions per configuration.
  localparam int NC = 4;
  typedef struct { int v; int rs; int rt; int rd; int rw; int ld; int st; } ment_t;
  int    dep[NC] = '{3, 4, 3, 3};
  int    luc[NC] = '{1, 2, 1, 1};
  int    m2m[NC] = '{1, 1, 0, 1};
  int    cw[NC]  = '{16, 16, 16, 3};
  ment_t mp[NC][8];
  longint mcnt[NC];

  function automatic bit m_wr(int c, int k);
    return mp[c][k].v != 0 && mp[c][k].rw != 0 && mp[c][k].rd != 0;
  endfunction

  function automatic int m_sel(int c, int src);
    int r = (src == 0) ? mp[c][0].rs : mp[c][0].rt;
    if (mp[c][0].v == 0) return 0;
    for (int k = 1; k < dep[c]; k++)
      if (m_wr(c, k) && mp[c][k].rd == r) return k;
    return 0;
  endfunction

  function automatic int m_stall(int c);
    if (!id_valid || flush) return 0;
    for (int k = 0; k < luc[c]; k++) begin
      if (m_wr(c, k) && mp[c][k].ld != 0) begin
        if (mp[c][k].rd == int'(id_rs)) return 1;
        if (mp[c][k].rd == int'(id_rt) &&
            !(m2m[c] != 0 && id_memwrite && k == luc[c] - 1)) return 1;
      end
    end
    return 0;
  endfunction

  function automatic int m_c(int c);
    return (m2m[c] != 0 && mp[c][1].v != 0 && mp[c][1].st != 0 && m_wr(c, 2) &&
            mp[c][2].rd == mp[c][1].rt && mp[c][1].rt != 0) ? 1 : 0;
  endfunction

  task automatic m_reset();
    for (int c = 0; c < NC; c++) begin
      mcnt[c] = 0;
      for (int k = 0; k < 8; k++) mp[c][k] = '{0, 0, 0, 0, 0, 0, 0};
    end
  endtask

  task automatic m_step();
    for (int c = 0; c < NC; c++) begin
      int s = m_stall(c);
      if (s != 0 && mcnt[c] < (64'd1 << cw[c]) - 1) mcnt[c]++;
      for (int k = dep[c] - 1; k >= 1; k--) mp[c][k] = mp[c][k-1];
      if (flush) mp[c][1].v = 0;
      if (s == 0 && !flush && id_valid)
        mp[c][0] = '{1, int'(id_rs), int'(id_rt), int'(id_rd), int'(id_regwrite),
                     int'(id_memread), int'(id_memwrite)};
      else
        mp[c][0] = '{0, 0, 0, 0, 0, 0, 0};
    end
  endtask

  task automatic rd_out(input int c, output logic [31:0] s, a, b, cc, n);
    case (c)
      0: begin s = {31'b0, s0}; a = {30'b0, a0}; b = {30'b0, b0}; cc = {31'b0, c0}; n = {16'b0, n0}; end
      1: begin s = {31'b0, s1}; a = {30'b0, a1}; b = {30'b0, b1}; cc = {31'b0, c1}; n = {16'b0, n1}; end
      2: begin s = {31'b0, s2}; a = {30'b0, a2}; b = {30'b0, b2}; cc = {31'b0, c2}; n = {16'b0, n2}; end
      default: begin s = {31'b0, s3}; a = {30'b0, a3}; b = {30'b0, b3}; cc = {31'b0, c3}; n = {29'b0, n3}; end
    endcase
  endtask

  task automatic apply(input int v, rs, rt, rd, rw, mr, mw, fl);
    @(negedge clk);
    id_valid = 1'(v); id_rs = 4'(rs); id_rt = 4'(rt); id_rd = 4'(rd);
    id_regwrite = 1'(rw); id_memread = 1'(mr); id_memwrite = 1'(mw); flush = 1'(fl);
    #1;
  endtask

  task automatic tick();
    m_step();
    @(posedge clk);
  endtask

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_regwrite = 0; id_memread = 0; id_memwrite = 0; flush = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; idle(); m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  typedef struct { int v; int rs; int rt; int rd; int rw; int mr; int mw; int fl;
                   int st; int a; int b; int c; int cnt; } vec_t;
  vec_t tbl[28];

  initial begin
    logic [31:0] s, a, b, cc, n;
    tbl = '{
      '{1,1,2,3,1,0,0,0, 0,0,0,0,0},  // ADD r3,r1,r2
      '{1,3,3,5,1,0,0,0, 0,0,0,0,0},  // SUB r5,r3,r3
      '{0,0,0,0,0,0,0,0, 0,1,1,0,0},  // SUB in EX: both from MEM
      '{1,1,1,3,1,0,0,0, 0,0,0,0,0},  // ADD r3
      '{1,2,2,3,1,0,0,0, 0,0,0,0,0},  // ADD r3
      '{1,3,7,5,1,0,0,0, 0,0,0,0,0},  // SUB r5,r3,r7
      '{0,0,0,0,0,0,0,0, 0,1,0,0,0},  // youngest producer wins
      '{1,1,1,3,1,0,0,0, 0,0,0,0,0},  // ADD r3
      '{0,0,0,0,0,0,0,0, 0,0,0,0,0},  // NOP
      '{1,3,0,4,1,0,0,0, 0,0,0,0,0},  // SUB r4,r3,r0
      '{0,0,0,0,0,0,0,0, 0,2,0,0,0},  // distance 2 -> WB
      '{1,1,0,2,1,1,0,0, 0,0,0,0,0},  // LW r2
      '{1,2,1,4,1,0,0,0, 1,0,0,0,0},  // ADD r4,r2,r1 -> stall
      '{1,2,1,4,1,0,0,0, 0,0,0,0,1},  // held, bubble in EX
      '{0,0,0,0,0,0,0,0, 0,2,0,0,1},  // ADD in EX: load from WB
      '{1,1,0,2,1,1,0,0, 0,0,0,0,1},  // LW r2
      '{1,1,2,0,0,0,1,0, 0,0,0,0,1},  // SW r2: exempt
      '{0,0,0,0,0,0,0,0, 0,0,1,0,1},  // SW in EX
      '{0,0,0,0,0,0,0,0, 0,0,0,1,1},  // SW in MEM: mem-to-mem
      '{1,1,1,0,1,0,0,0, 0,0,0,0,1},  // ADD r0
      '{1,0,0,5,1,0,0,0, 0,0,0,0,1},  // SUB r5,r0,r0
      '{0,0,0,0,0,0,0,0, 0,0,0,0,1},  // r0 never forwarded
      '{1,1,0,0,1,1,0,0, 0,0,0,0,1},  // LW r0
      '{1,0,0,4,1,0,0,0, 0,0,0,0,1},  // r0 consumer: no stall
      '{1,1,0,2,1,1,0,0, 0,0,0,0,1},  // LW r2
      '{1,2,1,4,1,0,0,1, 0,0,0,0,1},  // dependent + flush -> no stall
      '{1,2,4,6,1,0,0,0, 0,0,0,0,1},  // ADD r6,r2,r4
      '{0,0,0,0,0,0,0,0, 0,0,0,0,1}   // flushed pair gone
    };

    m_reset();
    #2;
    for (int c = 0; c < NC; c++) begin
      rd_out(c, s, a, b, cc, n);
      chk($sformatf("reset c%0d stall", c), s, 0);
      chk($sformatf("reset c%0d fwd", c), a | b | cc, 0);
      chk($sformatf("reset c%0d count", c), n, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 28; i++) begin
      apply(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].rw, tbl[i].mr, tbl[i].mw, tbl[i].fl);
      chk($sformatf("tbl%0d stall", i), {31'b0, s0}, tbl[i].st);
      chk($sformatf("tbl%0d fwd_a", i), {30'b0, a0}, tbl[i].a);
      chk($sformatf("tbl%0d fwd_b", i), {30'b0, b0}, tbl[i].b);
      chk($sformatf("tbl%0d fwd_c", i), {31'b0, c0}, tbl[i].c);
      chk($sformatf("tbl%0d count", i), {16'b0, n0}, tbl[i].cnt);
      tick();
    end

    // LOAD_USE_CYC=2, DEPTH=4: two stall cycles then forward from stage 3
    do_reset();
    apply(1,1,0,2,1,1,0,0); tick();
    apply(1,2,1,4,1,0,0,0); chk("luc2 stall1", {31'b0, s1}, 1); tick();
    apply(1,2,1,4,1,0,0,0); chk("luc2 stall2", {31'b0, s1}, 1); tick();
    apply(1,2,1,4,1,0,0,0); chk("luc2 release", {31'b0, s1}, 0); tick();
    apply(0,0,0,0,0,0,0,0);
    chk("luc2 fwd_a", {30'b0, a1}, 3);
    chk("luc2 count", {16'b0, n1}, 2);
    tick();

    // M2M_EN=0: load then store of the loaded register stalls once
    do_reset();
    apply(1,1,0,2,1,1,0,0); tick();
    apply(1,1,2,0,0,0,1,0);
    chk("nm stall", {31'b0, s2}, 1);
    chk("m2m exempt", {31'b0, s0}, 0);
    tick();
    apply(1,1,2,0,0,0,1,0); chk("nm release", {31'b0, s2}, 0); tick();
    apply(0,0,0,0,0,0,0,0);
    chk("nm fwd_b", {30'b0, b2}, 2);
    chk("nm fwd_c ex", {31'b0, c2}, 0);
    tick();
    apply(0,0,0,0,0,0,0,0); chk("nm fwd_c mem", {31'b0, c2}, 0); tick();

    // Asynchronous reset in the middle of a stall
    do_reset();
    apply(1,2,0,2,1,1,0,0); tick();
    apply(1,2,0,2,1,1,0,0); tick();
    apply(1,2,0,2,1,1,0,0); tick();
    apply(1,2,0,2,1,1,0,0);
    chk("midrst pre stall", {31'b0, s0}, 1);
    chk("midrst pre count", {16'b0, n0}, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst stall", {31'b0, s0}, 0);
    chk("midrst sel", {30'b0, a0 | b0}, 0);
    chk("midrst count", {16'b0, n0}, 0);
    m_reset();
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Saturation: 10 stall cycles against a 3-bit counter
    do_reset();
    for (int i = 0; i < 20; i++) begin
      apply(1,2,0,2,1,1,0,0);
      tick();
    end
    apply(0,0,0,0,0,0,0,0);
    chk("sat cnt3", {29'b0, n3}, 7);
    chk("sat cnt16", {16'b0, n0}, 10);
    tick();

    // Randomized traffic against the model, all configurations
    do_reset();
    for (int i = 0; i < 300; i++) begin
      int mr;
      mr = ($urandom_range(0, 2) == 0) ? 1 : 0;
      apply(($urandom_range(0, 9) < 8) ? 1 : 0, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), (mr != 0 || $urandom_range(0, 1) == 1) ? 1 : 0, mr,
            (mr == 0 && $urandom_range(0, 3) == 0) ? 1 : 0,
            ($urandom_range(0, 9) == 0) ? 1 : 0);
      for (int c = 0; c < NC; c++) begin
        rd_out(c, s, a, b, cc, n);
        chk($sformatf("rnd%0d c%0d stall", i, c), s, m_stall(c));
        chk($sformatf("rnd%0d c%0d fwd_a", i, c), a, m_sel(c, 0));
        chk($sformatf("rnd%0d c%0d fwd_b", i, c), b, m_sel(c, 1));
        chk($sformatf("rnd%0d c%0d fwd_c", i, c), cc, m_c(c));
        chk($sformatf("rnd%0d c%0d count", i, c), n, 32'(mcnt[c]));
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the 2-stage forwarding logic. Holds its own in-flight tag pipeline (EX, MEM, WB, and deeper stages when DEPTH is raised) and produces ALU operand forward selects for the EX instruction.
- Also produces the MEM-stage store-data (mem-to-mem) forward select and detects load-use hazards, generating stall and bubble.
- Keeps a saturating stall counter for performance profiling.
- Sits beside the ID/EX pipeline register in the WISC core; the datapath muxes consume its selects.

Parameters:
- REG_AW, 4, register address width (register 0 is hard-wired zero).
- DEPTH, 3, tracked stages after ID: entry0 = EX, entry1 = MEM, entry2 = WB, and so on; legal range 2..8.
- SEL_W, clog2(DEPTH), width of the operand forward selects.
- LOAD_USE_CYC, 1, number of stall cycles a load imposes on a dependent consumer; legal range 1..DEPTH-1.
- M2M_EN, 1, enables mem-to-mem store-data forwarding and the matching stall exemption.
- CNT_W, 16, stall counter width.

Ports:
- clk, input, 1, core clock.
- rst_n, input, 1, asynchronous active-low reset.
- id_valid, input, 1, ID holds a real instruction.
- id_rs, input, REG_AW, ID source A.
- id_rt, input, REG_AW, ID source B / store data register.
- id_rd, input, REG_AW, ID destination.
- id_regwrite, input, 1, ID instruction writes rd.
- id_memread, input, 1, ID instruction is a load.
- id_memwrite, input, 1, ID instruction is a store.
- flush, input, 1, kill the ID and EX instructions (branch redirect).
- stall, output, 1, hold PC and IF/ID; bubble enters EX.
- fwd_a_sel, output, SEL_W, EX operand A source.
- fwd_b_sel, output, SEL_W, EX operand B source.
- fwd_c_sel, output, 1, MEM store-data taken from WB result.
- stall_count, output, CNT_W, saturating count of stall cycles.

Behaviour:
- Each entry holds: v, rs, rt, rd, rw, ld, st.
- Reset (rst_n low, asynchronous): all entries cleared (v=0), stall_count=0. All outputs then evaluate to 0.
- "Writer k" means entry k with v & rw & rd!=0.
- Update at each posedge:
  - Entry0 loads {id_valid, id fields} when stall=0 and flush=0; otherwise entry0 loads a bubble (v=0).
  - Entry k (k≥1) loads entry k-1 unconditionally.
  - A flush also clears entry1's source: the EX instruction is converted to a bubble as it moves to MEM, so entry1 gets v=0.
- fwd_a_sel (combinational, zero latency): smallest k in 1..DEPTH-1 with writer k and entry k rd == entry0 rs, and entry0 v=1; else 0. The youngest producer wins. rs==0 always gives 0. fwd_b_sel is the same using entry0 rt.
- Encoding at default depth: 0 = register file, 1 = MEM result, 2 = WB result.
- fwd_c_sel = M2M_EN & entry1 v & entry1 st & writer 2 & entry2 rd == entry1 rt & entry1 rt != 0.
- stall (combinational) = id_valid & !flush & there exists k in 0..LOAD_USE_CYC-1 with writer k & entry k ld, and entry k rd matching id_rs, or matching id_rt.
  - Exemption: when M2M_EN=1, id_memwrite=1, the only match is id_rt, and k == LOAD_USE_CYC-1, this is not a stall (data is supplied by fwd_c_sel).
- Stall sequencing: no explicit FSM. Bubbles shifting through the entries clear the stall after exactly LOAD_USE_CYC cycles for a dependency in EX.
- Flush priority: flush forces stall=0.
- id_valid=0: stall=0 and a bubble enters.
- stall_count increments each cycle stall=1 and saturates at all-ones (no wrap).
- Non-load writers never cause a stall; forwarding covers them.
- Reset asserted mid-stall: stall drops immediately once the entries clear; no pending state survives.

Test Plan:
- Back-to-back ALU ops: ADD r3 then SUB r5,r3,r3 → in the SUB's EX cycle fwd_a_sel=1, fwd_b_sel=1, stall never asserted.
- Distance-2 and double producer: ADD r3; ADD r3; SUB r5,r3,r7 → fwd_a_sel=1 (youngest wins), fwd_b_sel=0. Also ADD r3; NOP; SUB r4,r3,r0 → fwd_a_sel=2.
- Load-use: LW r2; ADD r4,r2,r1 → stall=1 for exactly 1 cycle, bubble in EX, then fwd_a_sel=2, stall_count=1. Repeat with LOAD_USE_CYC=2 → stall 2 cycles, then fwd_a_sel=3 (DEPTH=4).
- Mem-to-mem: LW r2; SW r2 → no stall, and fwd_c_sel=1 in the SW's MEM cycle. Repeat with M2M_EN=0 → 1-cycle stall, fwd_c_sel=0.
- Zero register and flush: a writer to r0 followed by a consumer of r0 → all selects 0, no stall. Also LW r2 in EX with flush=1 and a dependent op in ID → stall=0, and the next-cycle entry0 v=0.
- Reset and saturation: assert rst_n=0 mid-stall → stall and selects 0 asynchronously, stall_count=0. Separately, with CNT_W=3, force 10 stall cycles → stall_count holds at 7.
